aes_job_scheduler: RTL and testbench
====================================

Name: aes_job_scheduler

Overview:
- Shares one aes256 pipeline core between NREQ requesters (e.g. DMA engine, CPU mailbox).
- Round-robin arbitrates job requests and drives the core's start code and block length.
- Holds the core start code for the whole job, waits for the core's sticky done, then flushes the core with a soft reset.
- Returns per-requester done/error pulses; a watchdog recovers from a hung core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 4096, watchdog limit in clkIn cycles from start to core done.
- FLUSH_CYC, 2, cycles coreRstnOut is held low after each job.

Ports:
- clkIn  in  1  clock
- resetIn  in  1  asynchronous, active-low reset
- reqIn  in  NREQ  level request per requester; held until that requester's doneOut or errOut
- modeIn  in  2*NREQ  per-requester code, slice i = [2i+1:2i]; 1=encrypt, 2=decrypt, 0/3 invalid
- lenIn  in  9*NREQ  per-requester block length, slice i = [9i+8:9i]
- grantOut  out  NREQ  one-hot, current job owner (drives BRAM mux outside)
- doneOut  out  NREQ  1-cycle pulse on job success
- errOut  out  NREQ  1-cycle pulse on reject or timeout
- busyOut  out  1  high in every state except IDLE
- coreStartOut  out  2  to core startIn
- coreLengthOut  out  9  to core lengthIn
- coreRstnOut  out  1  active-low soft reset to core
- coreDoneIn  in  3  core doneOut; 3'b111 = complete

Behaviour:
- Reset values: grantOut=0, doneOut=0, errOut=0, busyOut=0, coreStartOut=0, coreLengthOut=0, coreRstnOut=0, rrPtr=0, watchdog=0.
- Reset: coreRstnOut stays 0 until resetIn deasserts and the first FLUSH completes. The FSM leaves reset in FLUSH.
- States: IDLE, CHECK, START, BUSY, FLUSH.
- IDLE:
  - Scan reqIn from index rrPtr upward, with wrap.
  - First set bit g wins. Register grantOut=onehot(g); latch mode and length from slice g.
  - Go to CHECK.
  - No request: stay in IDLE.
- CHECK:
  - If latched mode is 0 or 3, or latched length is 0: pulse errOut[g], clear grantOut, set rrPtr=g+1 (mod NREQ), go to IDLE.
  - Otherwise: set coreLengthOut=len, go to START.
- START:
  - Drive coreStartOut=mode; clear watchdog; go to BUSY.
- BUSY:
  - coreStartOut and coreLengthOut are held constant. Changes on reqIn, modeIn and lenIn are ignored.
  - watchdog increments every cycle.
  - If coreDoneIn==3'b111: pulse doneOut[g], go to FLUSH.
  - Else if watchdog==TIMEOUT-1: pulse errOut[g], go to FLUSH.
  - If done and timeout occur in the same cycle, done wins.
- FLUSH:
  - coreStartOut=0, coreRstnOut=0 for FLUSH_CYC cycles (down-counter).
  - grantOut is cleared on FLUSH entry.
  - rrPtr=g+1 (mod NREQ).
  - On exit, coreRstnOut=1 and the FSM goes to IDLE.
- Latency, request to coreStartOut: 3 cycles (IDLE, CHECK, START).
- Latency, core done to doneOut: 1 cycle (registered).
- Minimum gap between jobs: FLUSH_CYC+3 cycles.
- Output exclusivity: doneOut and errOut are never both high. At most one bit of either is set in any cycle.
- Requester dropping reqIn mid-job: the job still completes and the pulse is still issued.
- Requester re-asserting immediately: gets no priority over other pending requesters.
- resetIn asserted mid-job: immediate return to reset values. No done or err pulse.

Decomposition:
- Package aes_sched_pkg:
  - state encoding localparams.
  - MODE_ENC=2'd1, MODE_DEC=2'd2.
  - CORE_DONE=3'b111.
  - LEN_W=9.
- Sub-module rr_arbiter (NREQ, reqIn, rrPtr -> onehot grant + index), purely combinational priority rotate, instantiated once.
- The FSM, watchdog and flush counter stay in aes_job_scheduler.

Test Plan:
- Single job: req0, mode=1, len=16 → coreStartOut=1 three cycles after req; stub core raises done after 45 cycles → doneOut[0] one cycle later; coreRstnOut low 2 cycles; busyOut falls.
- Contention: req0..3 all high, each job len=4 → grant order 0,1,2,3,0; each done pulse matches the current grantOut.
- Reject: req2, mode=3 → errOut[2] in CHECK cycle; coreStartOut stays 0. Repeat with mode=2, len=0 → error.
- Timeout: TIMEOUT=64, stub never sets done → errOut[g] at cycle 64 after START, then FLUSH, then the next requester is served.
- Simultaneous: done and timeout in the same cycle → only doneOut pulses.
- Mid-job async reset: resetIn low during BUSY → all outputs at reset values within the same cycle; after release, FLUSH then IDLE; no stale pulses.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the aes256 job scheduler.
package aes_sched_pkg;

  localparam int unsigned LEN_W  = 9;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned DONE_W = 3;
  localparam int unsigned ST_W   = 3;

  localparam logic [MODE_W-1:0] MODE_ENC  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_DEC  = 2'd2;
  localparam logic [DONE_W-1:0] CORE_DONE = 3'b111;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  // Only encrypt and decrypt are codes the core accepts.
  function automatic logic mode_ok(input logic [MODE_W-1:0] m);
    return (m == MODE_ENC) || (m == MODE_DEC);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] pos_c;

  // Rotate the scan start to ptr and take the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos_c = IDX_W'((32'(ptr) + i) % NREQ);
      if (!valid && req[pos_c]) begin
        valid        = 1'b1;
        idx          = pos_c;
        grant[pos_c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one aes256 core between NREQ requesters: arbitrate, start, watch, flush.
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic [NREQ-1:0]         reqIn,
  input  logic [MODE_W*NREQ-1:0]  modeIn,
  input  logic [LEN_W*NREQ-1:0]   lenIn,
  output logic [NREQ-1:0]         grantOut,
  output logic [NREQ-1:0]         doneOut,
  output logic [NREQ-1:0]         errOut,
  output logic                    busyOut,
  output logic [MODE_W-1:0]       coreStartOut,
  output logic [LEN_W-1:0]        coreLengthOut,
  output logic                    coreRstnOut,
  input  logic [DONE_W-1:0]       coreDoneIn
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned FL_W  = $clog2(FLUSH_CYC + 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [MODE_W-1:0]  job_mode;
  logic [LEN_W-1:0]   job_len;
  logic [WD_W-1:0]    watchdog;
  logic [FL_W-1:0]    flush_cnt;

  logic [NREQ-1:0]    arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [MODE_W-1:0]  sel_mode_c;
  logic [LEN_W-1:0]   sel_len_c;
  logic [IDX_W-1:0]   next_ptr_c;
  logic               core_done_c;
  logic               timeout_c;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (reqIn),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Mux the winning requester's mode and length slices.
  always_comb begin
    sel_mode_c = '0;
    sel_len_c  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        sel_mode_c = modeIn[MODE_W*i +: MODE_W];
        sel_len_c  = lenIn[LEN_W*i +: LEN_W];
      end
    end
  end

  // Pointer moves just past the current owner; core status decode.
  always_comb begin
    next_ptr_c  = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    core_done_c = (coreDoneIn == CORE_DONE);
    timeout_c   = (watchdog == WD_W'(TIMEOUT - 1));
  end

  // Job FSM with watchdog and flush counter; all outputs registered.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state         <= ST_FLUSH;
      rr_ptr        <= '0;
      gnt_idx       <= '0;
      job_mode      <= '0;
      job_len       <= '0;
      watchdog      <= '0;
      flush_cnt     <= FL_W'(FLUSH_CYC - 1);
      grantOut      <= '0;
      doneOut       <= '0;
      errOut        <= '0;
      busyOut       <= 1'b0;
      coreStartOut  <= '0;
      coreLengthOut <= '0;
      coreRstnOut   <= 1'b0;
    end else begin
      doneOut <= '0;
      errOut  <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grantOut <= arb_grant;
            gnt_idx  <= arb_idx;
            job_mode <= sel_mode_c;
            job_len  <= sel_len_c;
            busyOut  <= 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!mode_ok(job_mode) || (job_len == '0)) begin
            errOut   <= grantOut;
            grantOut <= '0;
            rr_ptr   <= next_ptr_c;
            busyOut  <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            coreLengthOut <= job_len;
            state         <= ST_START;
          end
        end
        ST_START: begin
          coreStartOut <= job_mode;
          watchdog     <= '0;
          state        <= ST_BUSY;
        end
        ST_BUSY: begin
          watchdog <= watchdog + WD_W'(1);
          if (core_done_c || timeout_c) begin
            if (core_done_c) doneOut <= grantOut;
            else             errOut  <= grantOut;
            grantOut     <= '0;
            coreStartOut <= '0;
            coreRstnOut  <= 1'b0;
            rr_ptr       <= next_ptr_c;
            flush_cnt    <= FL_W'(FLUSH_CYC - 1);
            state        <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          coreStartOut <= '0;
          if (flush_cnt == '0) begin
            coreRstnOut <= 1'b1;
            busyOut     <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - FL_W'(1);
            busyOut   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a hand-driven stub core.
module tb_aes_job_scheduler;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned TIMEOUT   = 64;
  localparam int unsigned FLUSH_CYC = 2;

  logic              clkIn = 1'b0;
  logic              resetIn;
  logic [NREQ-1:0]   reqIn;
  logic [2*NREQ-1:0] modeIn;
  logic [9*NREQ-1:0] lenIn;
  logic [NREQ-1:0]   grantOut;
  logic [NREQ-1:0]   doneOut;
  logic [NREQ-1:0]   errOut;
  logic              busyOut;
  logic [1:0]        coreStartOut;
  logic [8:0]        coreLengthOut;
  logic              coreRstnOut;
  logic [2:0]        coreDoneIn;

  int n_checks = 0;
  int n_errors = 0;

  aes_job_scheduler #(
    .NREQ      (NREQ),
    .TIMEOUT   (TIMEOUT),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .clkIn         (clkIn),
    .resetIn       (resetIn),
    .reqIn         (reqIn),
    .modeIn        (modeIn),
    .lenIn         (lenIn),
    .grantOut      (grantOut),
    .doneOut       (doneOut),
    .errOut        (errOut),
    .busyOut       (busyOut),
    .coreStartOut  (coreStartOut),
    .coreLengthOut (coreLengthOut),
    .coreRstnOut   (coreRstnOut),
    .coreDoneIn    (coreDoneIn)
  );

  always #5 clkIn = ~clkIn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int unsigned i, input logic [1:0] m, input logic [8:0] l);
    modeIn[2*i +: 2] = m;
    lenIn[9*i +: 9]  = l;
    reqIn[i]         = 1'b1;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_grant"}, 32'(grantOut), 32'h0);
    chk({pfx, "_done"},  32'(doneOut), 32'h0);
    chk({pfx, "_err"},   32'(errOut), 32'h0);
    chk({pfx, "_busy"},  32'(busyOut), 32'h0);
    chk({pfx, "_start"}, 32'(coreStartOut), 32'h0);
    chk({pfx, "_len"},   32'(coreLengthOut), 32'h0);
    chk({pfx, "_rstn"},  32'(coreRstnOut), 32'h0);
  endtask

  // One contention job: bounded wait for grant and start, then stub done.
  task automatic run_job(input int unsigned g, input logic [1:0] m, input int gap);
    int n;
    n = 0;
    while (grantOut == '0 && n < 20) begin tick(); n++; end
    chk("cont_grant", 32'(grantOut), 32'(1 << g));
    chk("cont_gap", 32'(n), 32'(gap));
    n = 0;
    while (coreStartOut == '0 && n < 20) begin tick(); n++; end
    chk("cont_start_lat", 32'(n), 32'd2);
    chk("cont_mode", 32'(coreStartOut), 32'(m));
    chk("cont_len", 32'(coreLengthOut), 32'd4);
    ticks(3);
    coreDoneIn = 3'b111;
    tick();
    chk("cont_done", 32'(doneOut), 32'(1 << g));
    chk("cont_err", 32'(errOut), 32'h0);
    coreDoneIn = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    resetIn    = 1'b0;
    reqIn      = '0;
    modeIn     = '0;
    lenIn      = '0;
    coreDoneIn = 3'b000;
    ticks(3);
    chk_reset("rst");

    // Leave reset through the initial flush.
    resetIn = 1'b1;
    tick();
    chk("rst_flush_rstn", 32'(coreRstnOut), 32'h0);
    tick();
    chk("rst_exit_rstn", 32'(coreRstnOut), 32'h1);
    chk("rst_exit_busy", 32'(busyOut), 32'h0);

    // Single job on requester 0.
    set_req(0, 2'd1, 9'd16);
    tick();
    chk("single_grant", 32'(grantOut), 32'h1);
    chk("single_start_early", 32'(coreStartOut), 32'h0);
    ticks(2);
    chk("single_start", 32'(coreStartOut), 32'h1);
    chk("single_len", 32'(coreLengthOut), 32'd16);
    chk("single_busy", 32'(busyOut), 32'h1);
    ticks(44);
    chk("single_no_done", 32'(doneOut), 32'h0);
    chk("single_start_held", 32'(coreStartOut), 32'h1);
    coreDoneIn = 3'b111;
    tick();
    chk("single_done", 32'(doneOut), 32'h1);
    chk("single_err", 32'(errOut), 32'h0);
    chk("single_grant_clr", 32'(grantOut), 32'h0);
    chk("single_rstn_lo", 32'(coreRstnOut), 32'h0);
    chk("single_start_clr", 32'(coreStartOut), 32'h0);
    reqIn      = '0;
    coreDoneIn = 3'b000;
    tick();
    chk("single_done_pulse", 32'(doneOut), 32'h0);
    chk("single_rstn_lo2", 32'(coreRstnOut), 32'h0);
    tick();
    chk("single_rstn_hi", 32'(coreRstnOut), 32'h1);
    chk("single_idle", 32'(busyOut), 32'h0);

    // Reject: invalid mode, then zero length.
    set_req(2, 2'd3, 9'd5);
    tick();
    chk("rej1_grant", 32'(grantOut), 32'h4);
    tick();
    chk("rej1_err", 32'(errOut), 32'h4);
    chk("rej1_grant_clr", 32'(grantOut), 32'h0);
    chk("rej1_start", 32'(coreStartOut), 32'h0);
    chk("rej1_done", 32'(doneOut), 32'h0);
    reqIn = '0;
    tick();
    chk("rej1_err_pulse", 32'(errOut), 32'h0);
    set_req(2, 2'd2, 9'd0);
    tick();
    chk("rej2_grant", 32'(grantOut), 32'h4);
    tick();
    chk("rej2_err", 32'(errOut), 32'h4);
    chk("rej2_start", 32'(coreStartOut), 32'h0);
    reqIn = '0;
    tick();

    // Timeout on requester 3, then requester 1 is served.
    set_req(3, 2'd1, 9'd8);
    set_req(1, 2'd2, 9'd12);
    tick();
    chk("to_grant", 32'(grantOut), 32'h8);
    ticks(2);
    chk("to_start", 32'(coreStartOut), 32'h1);
    chk("to_len", 32'(coreLengthOut), 32'd8);
    ticks(63);
    chk("to_err_early", 32'(errOut), 32'h0);
    chk("to_start_held", 32'(coreStartOut), 32'h1);
    tick();
    chk("to_err", 32'(errOut), 32'h8);
    chk("to_done", 32'(doneOut), 32'h0);
    chk("to_grant_clr", 32'(grantOut), 32'h0);
    chk("to_rstn", 32'(coreRstnOut), 32'h0);
    reqIn[3] = 1'b0;
    ticks(2);
    chk("to_rstn_hi", 32'(coreRstnOut), 32'h1);
    tick();
    chk("to_next_grant", 32'(grantOut), 32'h2);
    ticks(2);
    chk("to_next_start", 32'(coreStartOut), 32'h2);
    chk("to_next_len", 32'(coreLengthOut), 32'd12);
    coreDoneIn = 3'b111;
    tick();
    chk("to_next_done", 32'(doneOut), 32'h2);
    reqIn      = '0;
    coreDoneIn = 3'b000;
    ticks(2);

    // Done and timeout land in the same cycle; busy ignores input changes.
    set_req(0, 2'd2, 9'd100);
    tick();
    chk("sim_grant", 32'(grantOut), 32'h1);
    ticks(2);
    chk("sim_start", 32'(coreStartOut), 32'h2);
    ticks(30);
    modeIn[1:0] = 2'd1;
    lenIn[8:0]  = 9'd7;
    ticks(33);
    chk("sim_start_held", 32'(coreStartOut), 32'h2);
    chk("sim_len_held", 32'(coreLengthOut), 32'd100);
    chk("sim_err_early", 32'(errOut), 32'h0);
    coreDoneIn = 3'b111;
    tick();
    chk("sim_done", 32'(doneOut), 32'h1);
    chk("sim_err", 32'(errOut), 32'h0);
    reqIn      = '0;
    coreDoneIn = 3'b000;
    ticks(2);

    // Asynchronous reset in the middle of a job.
    set_req(2, 2'd1, 9'd20);
    ticks(3);
    chk("mrst_start", 32'(coreStartOut), 32'h1);
    ticks(5);
    resetIn = 1'b0;
    #1;
    chk_reset("mrst");
    reqIn = '0;
    tick();
    resetIn = 1'b1;
    tick();
    chk("mrst_flush_rstn", 32'(coreRstnOut), 32'h0);
    chk("mrst_flush_done", 32'(doneOut), 32'h0);
    chk("mrst_flush_err", 32'(errOut), 32'h0);
    tick();
    chk("mrst_rstn_hi", 32'(coreRstnOut), 32'h1);
    chk("mrst_done", 32'(doneOut), 32'h0);
    chk("mrst_err", 32'(errOut), 32'h0);
    chk("mrst_idle", 32'(busyOut), 32'h0);

    // Contention: all four held high, order 0,1,2,3,0.
    set_req(0, 2'd1, 9'd4);
    set_req(1, 2'd2, 9'd4);
    set_req(2, 2'd1, 9'd4);
    set_req(3, 2'd2, 9'd4);
    run_job(0, 2'd1, 1);
    run_job(1, 2'd2, 3);
    run_job(2, 2'd1, 3);
    run_job(3, 2'd2, 3);
    run_job(0, 2'd1, 3);
    reqIn = '0;
    ticks(3);
    chk("end_idle", 32'(busyOut), 32'h0);
    chk("end_grant", 32'(grantOut), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
